// File: rtl/execute_stage_muldiv_pkg.sv
// rtl/execute_stage_muldiv_pkg.sv - shared control, forwarding and mul/div types for the EX stage
package execute_stage_muldiv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_op_type;

    // Encoding equals RV32M funct3.
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_type;

    typedef struct packed {
        logic          RegWrite;
        logic          MemRead;
        logic          MemWrite;
        logic          MemtoReg;
        logic          ALUSrc;
        alu_op_type    ALUOp;
        logic          IsMulDiv;
        muldiv_op_type MulDivOp;
    } control_type;

    typedef enum logic [1:0] {
        FWD_REGFILE,
        FWD_MEM_WB,
        FWD_EX_MEM
    } mux_control_type;

    typedef enum logic [1:0] {
        MULDIV_IDLE,
        MULDIV_BUSY,
        MULDIV_DONE
    } muldiv_state_type;

endpackage

// File: rtl/execute_stage_muldiv_muldiv_unit.sv
// rtl/execute_stage_muldiv_muldiv_unit.sv - iterative RV32M multiply/divide with start/busy/done/flush
module muldiv_unit
    import execute_stage_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                start_i,
    input  muldiv_op_type       op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [XLEN-1:0]     result_o
);

    localparam int ITER = XLEN / BITS_PER_CYCLE;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(ITER - 1);
    localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_type  state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] prod_q, prod_d, step;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    muldiv_op_type     op_q, op_d;
    logic              neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;

    logic              a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag;

    // Product register holds {accumulator, multiplier}; LSB first.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                  input logic [XLEN-1:0]   m);
        logic [XLEN:0] hi;
        hi = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {hi, p[XLEN-1:1]};
    endfunction

    // Product register holds {remainder, dividend/quotient}; restoring, MSB first.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] p,
                                                  input logic [XLEN-1:0]   d);
        logic [XLEN:0] rem;
        logic          q;
        rem = p[2*XLEN-1:XLEN-1];
        q   = (rem >= {1'b0, d});
        if (q) rem = rem - {1'b0, d};
        return {rem[XLEN-1:0], p[XLEN-2:0], q};
    endfunction

    always_comb begin
        a_signed = (op_i == MD_MULH) || (op_i == MD_MULHSU) || (op_i == MD_DIV) || (op_i == MD_REM);
        b_signed = (op_i == MD_MULH) || (op_i == MD_DIV) || (op_i == MD_REM);
        a_neg    = a_signed & a_i[XLEN-1];
        b_neg    = b_signed & b_i[XLEN-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = op_i[2] && b_signed && (a_i == XMIN) && (b_i == '1);
    end

    always_comb begin
        step = prod_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) step = div_step(step, opnd_q);
            else         step = mul_step(step, opnd_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        case (state_q)
            MULDIV_IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    cnt_d    = CNT_LAST;
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = op_i[2] ? a_neg : (a_neg ^ b_neg);
                    prod_d   = {{XLEN{1'b0}}, op_i[2] ? a_mag : b_mag};
                    opnd_d   = op_i[2] ? b_mag : a_mag;
                    state_d  = MULDIV_BUSY;
                    // Special cases preload the final {remainder, quotient} directly.
                    if (div_zero) begin
                        prod_d   = {a_i, {XLEN{1'b1}}};
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        state_d  = MULDIV_DONE;
                    end else if (div_ovf) begin
                        prod_d   = {{XLEN{1'b0}}, XMIN};
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        state_d  = MULDIV_DONE;
                    end
                end
            end
            MULDIV_BUSY: begin
                prod_d = step;
                if (cnt_q == '0) state_d = MULDIV_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            MULDIV_DONE: state_d = MULDIV_IDLE;
            default:     state_d = MULDIV_IDLE;
        endcase
        if (flush_i) state_d = MULDIV_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MULDIV_IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            opnd_q   <= '0;
            op_q     <= MD_MUL;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end

    logic [2*XLEN-1:0] full;
    logic [XLEN-1:0]   lo_raw, hi_raw;

    always_comb begin
        full   = neg_lo_q ? -prod_q : prod_q;
        lo_raw = prod_q[XLEN-1:0];
        hi_raw = prod_q[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                     result_o = full[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_o = full[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:            result_o = neg_lo_q ? -lo_raw : lo_raw;
            default:                    result_o = neg_hi_q ? -hi_raw : hi_raw;
        endcase
    end

    assign busy_o = (state_q == MULDIV_BUSY);
    assign done_o = (state_q == MULDIV_DONE);

endmodule

// File: rtl/execute_stage_muldiv.sv
// rtl/execute_stage_muldiv.sv - RV32 execute stage with forwarding, ALU and iterative mul/div
module execute_stage_muldiv
    import execute_stage_muldiv_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  control_type     control_in,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [XLEN-1:0] immediate_data,
    input  logic [4:0]      rd_in,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      ex_mem_rd,
    input  logic [4:0]      mem_wb_rd,
    input  logic            ex_mem_RegWrite,
    input  logic            mem_wb_RegWrite,
    input  logic [XLEN-1:0] forward_ex_mem,
    input  logic [XLEN-1:0] forward_mem_wb,
    output control_type     control_out,
    output logic            ZeroFlag,
    output logic [XLEN-1:0] alu_data,
    output logic [XLEN-1:0] memory_data,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd_out,
    output logic            out_valid,
    output logic            stall
);

    localparam int SHW = $clog2(XLEN);

    mux_control_type fwd_a, fwd_b;
    logic [XLEN-1:0] op_a, op_b, alu_b, alu_res;
    logic [SHW-1:0]  shamt;

    always_comb begin
        fwd_a = FWD_REGFILE;
        fwd_b = FWD_REGFILE;
        if (ex_mem_RegWrite && ex_mem_rd != 5'd0 && ex_mem_rd == rs1)      fwd_a = FWD_EX_MEM;
        else if (mem_wb_RegWrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs1) fwd_a = FWD_MEM_WB;
        if (ex_mem_RegWrite && ex_mem_rd != 5'd0 && ex_mem_rd == rs2)      fwd_b = FWD_EX_MEM;
        else if (mem_wb_RegWrite && mem_wb_rd != 5'd0 && mem_wb_rd == rs2) fwd_b = FWD_MEM_WB;
        case (fwd_a)
            FWD_EX_MEM: op_a = forward_ex_mem;
            FWD_MEM_WB: op_a = forward_mem_wb;
            default:    op_a = data1;
        endcase
        case (fwd_b)
            FWD_EX_MEM: op_b = forward_ex_mem;
            FWD_MEM_WB: op_b = forward_mem_wb;
            default:    op_b = data2;
        endcase
    end

    always_comb begin
        alu_b   = control_in.ALUSrc ? immediate_data : op_b;
        shamt   = alu_b[SHW-1:0];
        alu_res = op_a + alu_b;
        case (control_in.ALUOp)
            ALU_SUB:  alu_res = op_a - alu_b;
            ALU_AND:  alu_res = op_a & alu_b;
            ALU_OR:   alu_res = op_a | alu_b;
            ALU_XOR:  alu_res = op_a ^ alu_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(alu_b))};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < alu_b)};
            default:  alu_res = op_a + alu_b;
        endcase
    end

    logic            md_start, md_busy, md_done, md_idle;
    logic [XLEN-1:0] md_result;

    assign md_start = in_valid & control_in.IsMulDiv & ~flush;
    assign md_idle  = ~md_busy & ~md_done;

    muldiv_unit #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .flush_i  (flush),
        .start_i  (md_start),
        .op_i     (control_in.MulDivOp),
        .a_i      (op_a),
        .b_i      (op_b),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    control_type     ctrl_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            pc_q   <= '0;
            ctrl_q <= '0;
        end else if (md_start && md_idle) begin
            rd_q   <= rd_in;
            pc_q   <= pc;
            ctrl_q <= control_in;
        end
    end

    // Output mux selects on FSM state only, so BUSY never sees the live operands.
    always_comb begin
        alu_data    = '0;
        control_out = '0;
        rd_out      = '0;
        pc_out      = '0;
        out_valid   = 1'b0;
        memory_data = op_b;
        stall       = ((md_idle & md_start) | md_busy) & ~flush;
        if (md_done) begin
            alu_data    = md_result;
            control_out = ctrl_q;
            rd_out      = rd_q;
            pc_out      = pc_q;
            out_valid   = ~flush;
        end else if (md_idle && in_valid && !control_in.IsMulDiv) begin
            alu_data    = alu_res;
            control_out = control_in;
            rd_out      = rd_in;
            pc_out      = pc;
            out_valid   = ~flush;
        end
        ZeroFlag = (alu_data == '0);
    end

endmodule

// File: tb/tb_execute_stage_muldiv.sv
// tb/tb_execute_stage_muldiv.sv - directed self-checking bench for execute_stage_muldiv
module tb_execute_stage_muldiv;
    import execute_stage_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    control_type control_in, control_out;
    logic [31:0] pc, data1, data2, immediate_data;
    logic [4:0]  rd_in, rs1, rs2, ex_mem_rd, mem_wb_rd, rd_out;
    logic        ex_mem_RegWrite, mem_wb_RegWrite;
    logic [31:0] forward_ex_mem, forward_mem_wb;
    logic        ZeroFlag, out_valid, stall;
    logic [31:0] alu_data, memory_data, pc_out;

    int n_chk  = 0;
    int n_pass = 0;

    execute_stage_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
        .control_in(control_in), .pc(pc), .data1(data1), .data2(data2),
        .immediate_data(immediate_data), .rd_in(rd_in), .rs1(rs1), .rs2(rs2),
        .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .ex_mem_RegWrite(ex_mem_RegWrite), .mem_wb_RegWrite(mem_wb_RegWrite),
        .forward_ex_mem(forward_ex_mem), .forward_mem_wb(forward_mem_wb),
        .control_out(control_out), .ZeroFlag(ZeroFlag), .alu_data(alu_data),
        .memory_data(memory_data), .pc_out(pc_out), .rd_out(rd_out),
        .out_valid(out_valid), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic control_type md_ctrl(input muldiv_op_type op);
        control_type c;
        c = '0;
        c.RegWrite = 1'b1;
        c.IsMulDiv = 1'b1;
        c.MulDivOp = op;
        return c;
    endfunction

    function automatic control_type alu_ctrl(input alu_op_type op, input logic src);
        control_type c;
        c = '0;
        c.RegWrite = 1'b1;
        c.ALUSrc   = src;
        c.ALUOp    = op;
        return c;
    endfunction

    task automatic present(input control_type c, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [4:0] rd);
        in_valid        = 1'b1;
        control_in      = c;
        data1           = a;
        data2           = b;
        immediate_data  = imm;
        rd_in           = rd;
        pc              = 32'h0000_0124;
        rs1             = 5'd1;
        rs2             = 5'd2;
        ex_mem_RegWrite = 1'b0;
        mem_wb_RegWrite = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic run_md(input string tag, input muldiv_op_type op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input bit fwd);
        int  c;
        int  stalls;
        bit  seen;
        @(posedge clk); #1;
        present(md_ctrl(op), a, b, 32'h0, 5'd9);
        if (fwd) begin
            data1           = 32'h0000_1234;
            rs1             = 5'd5;
            ex_mem_rd       = 5'd5;
            ex_mem_RegWrite = 1'b1;
            forward_ex_mem  = a;
        end
        c = 0; stalls = 0; seen = 1'b0;
        while (!seen && c <= 60) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                if (stall) stalls++;
                @(posedge clk); #1;
                c++;
                if (fwd && c == 1) forward_ex_mem = 32'h0;
            end
        end
        chk({tag, " latency"}, 32'(c), 32'(lat));
        chk({tag, " stall cycles"}, 32'(stalls), 32'(lat));
        chk({tag, " result"}, alu_data, exp);
        chk({tag, " rd_out"}, {27'd0, rd_out}, 32'd9);
        chk({tag, " pc_out"}, pc_out, 32'h0000_0124);
        chk({tag, " stall in done"}, {31'd0, stall}, 32'd0);
    endtask

    initial begin
        int seen_valid;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; control_in = alu_ctrl(ALU_ADD, 1'b0);
        pc = 32'h0; data1 = 32'h5; data2 = 32'h6; immediate_data = 32'h0; rd_in = 5'd0;
        rs1 = 5'd0; rs2 = 5'd0; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
        ex_mem_RegWrite = 1'b0; mem_wb_RegWrite = 1'b0; forward_ex_mem = 32'h0; forward_mem_wb = 32'h0;
        #12;
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset alu_data", alu_data, 32'd0);
        chk("reset ZeroFlag", {31'd0, ZeroFlag}, 32'd1);
        rst = 1'b0;

        @(posedge clk); #1;
        present(alu_ctrl(ALU_ADD, 1'b1), 32'd10, 32'd99, 32'd5, 5'd3);
        @(negedge clk);
        chk("addi result", alu_data, 32'd15);
        chk("addi out_valid", {31'd0, out_valid}, 32'd1);
        chk("addi stall", {31'd0, stall}, 32'd0);
        chk("addi rd_out", {27'd0, rd_out}, 32'd3);

        @(posedge clk); #1;
        present(alu_ctrl(ALU_SUB, 1'b0), 32'd10, 32'd3, 32'd100, 5'd4);
        @(negedge clk);
        chk("sub result", alu_data, 32'd7);

        @(posedge clk); #1;
        present(alu_ctrl(ALU_ADD, 1'b0), 32'd1, 32'd2, 32'd0, 5'd4);
        rs1 = 5'd4; rs2 = 5'd4;
        ex_mem_rd = 5'd4; ex_mem_RegWrite = 1'b1; forward_ex_mem = 32'h10;
        mem_wb_rd = 5'd4; mem_wb_RegWrite = 1'b1; forward_mem_wb = 32'h20;
        @(negedge clk);
        chk("fwd ex_mem priority", alu_data, 32'h20);
        chk("fwd memory_data", memory_data, 32'h10);
        ex_mem_RegWrite = 1'b0;
        #1;
        chk("fwd mem_wb", alu_data, 32'h40);
        chk("fwd mem_wb memory_data", memory_data, 32'h20);

        @(posedge clk); #1;
        present(alu_ctrl(ALU_ADD, 1'b0), 32'd3, 32'd4, 32'd0, 5'd1);
        rs1 = 5'd0; rs2 = 5'd0; ex_mem_rd = 5'd0; ex_mem_RegWrite = 1'b1; forward_ex_mem = 32'h77;
        @(negedge clk);
        chk("x0 not forwarded", alu_data, 32'd7);

        @(posedge clk); #1;
        present(alu_ctrl(ALU_SUB, 1'b0), 32'd5, 32'd5, 32'd0, 5'd1);
        @(negedge clk);
        chk("sub zero ZeroFlag", {31'd0, ZeroFlag}, 32'd1);

        run_md("MUL",      MD_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run_md("MULH",     MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
        run_md("MULHU",    MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_md("MULHSU",   MD_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33, 1'b0);
        run_md("DIV",      MD_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 1'b0);
        run_md("REM",      MD_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 1'b0);
        run_md("DIVU",     MD_DIVU,   32'd100,      32'd7,        32'd14,        33, 1'b0);
        run_md("REMU",     MD_REMU,   32'd100,      32'd7,        32'd2,         33, 1'b0);
        run_md("DIVU /0",  MD_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF, 1,  1'b0);
        run_md("REM /0",   MD_REM,    32'd5,        32'd0,        32'd5,         1,  1'b0);
        run_md("DIV ovf",  MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_md("REM ovf",  MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1,  1'b0);
        chk("REM ovf ZeroFlag", {31'd0, ZeroFlag}, 32'd1);
        run_md("DIVU fwd", MD_DIVU,   32'd100,      32'd7,        32'd14,        33, 1'b1);

        // flush at cycle 5 of a MUL
        @(posedge clk); #1;
        present(md_ctrl(MD_MUL), 32'd3, 32'd4, 32'd0, 5'd9);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush stall", {31'd0, stall}, 32'd0);
        chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("flush no out_valid", 32'(seen_valid), 32'd0);
        chk("flush idle stall", {31'd0, stall}, 32'd0);

        // reset at cycle 10 of a MUL
        @(posedge clk); #1;
        present(md_ctrl(MD_MUL), 32'd3, 32'd4, 32'd0, 5'd9);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        chk("pre-reset busy stall", {31'd0, stall}, 32'd1);
        rst = 1'b1; in_valid = 1'b0;
        #2;
        chk("abort stall", {31'd0, stall}, 32'd0);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort alu_data", alu_data, 32'd0);
        chk("abort ZeroFlag", {31'd0, ZeroFlag}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        present(alu_ctrl(ALU_ADD, 1'b0), 32'd1, 32'd2, 32'd0, 5'd6);
        #1;
        chk("post-reset add", alu_data, 32'd3);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd1);
        chk("post-reset stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-reset add held", alu_data, 32'd3);
        chk("post-reset no stall", {31'd0, stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/execute_stage_muldiv.md
# execute_stage_muldiv

Parametrised execute stage for the 5-stage RV32 pipeline, adding an iterative RV32M multiply/divide path beside the single-cycle ALU. It sits between the ID/EX and EX/MEM registers and keeps operand forwarding from EX/MEM and MEM/WB. Base ALU operations complete combinationally. M-extension operations latch their forwarded operands, stall the front of the pipeline for a fixed number of cycles, then present the result for one cycle.

## Interface
Parameters:
- XLEN, 32, datapath width.
- BITS_PER_CYCLE, 1, radix of the iterative mul/div; legal values 1, 2, 4 (XLEN divisible by it).
- ITER, XLEN/BITS_PER_CYCLE (derived), iteration cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort of the in-flight mul/div.
- in_valid  in  1  ID/EX holds a real instruction (0 = bubble).
- control_in  in  control_type  decoded controls, including IsMulDiv and MulDivOp.
- pc, data1, data2, immediate_data  in  XLEN  ID/EX payload.
- rd_in, rs1, rs2, ex_mem_rd, mem_wb_rd  in  5  register addresses.
- ex_mem_RegWrite, mem_wb_RegWrite  in  1  forwarding qualifiers.
- forward_ex_mem, forward_mem_wb  in  XLEN  forwarded values.
- control_out  out  control_type  to EX/MEM.
- ZeroFlag  out  1  result == 0.
- alu_data, memory_data, pc_out  out  XLEN.
- rd_out  out  5.
- out_valid  out  1  EX/MEM may capture a real result this cycle.
- stall  out  1  hazard unit holds PC, IF/ID and ID/EX, and injects a bubble into EX/MEM.

## Operation
- Forwarding priority: EX/MEM over MEM/WB over the register file. rs = x0 is never forwarded. memory_data is the forwarded rs2.
- Base ALU ops: ALUSrc selects immediate_data as the right operand. Outputs pass through combinationally and out_valid = in_valid.
- M ops ignore ALUSrc and always use forwarded rs1/rs2.
- MulDivOp = funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Mul/div computation:
  - Signed operands are converted to magnitudes.
  - An unsigned shift-add multiply or restoring divide runs, BITS_PER_CYCLE bits per cycle, with a 2*XLEN product register.
  - The result is sign-corrected at DONE.
- Special cases are detected at issue and skip BUSY:
  - Divide by zero: quotient all ones, remainder = dividend.
  - Signed overflow (MIN / -1): quotient MIN, remainder 0.
- FSM states and transitions:
  - IDLE: if in_valid & IsMulDiv, latch operands, op, rd, pc and control, then go to BUSY, or to DONE for special cases.
  - BUSY: counter runs ITER-1 down to 0, then DONE.
  - DONE: drive the latched result, control, rd and pc; out_valid = 1; then IDLE.
- stall = (IDLE & in_valid & IsMulDiv & !flush) | BUSY. It is combinational and low in DONE.
- While stall = 1, out_valid = 0.
- In DONE the same instruction is still presented on the inputs; it must not re-issue.
- flush in any state returns to IDLE the next cycle and forces out_valid = 0 and stall = 0 in the flush cycle.
- Reset is asynchronous to IDLE:
  - counter 0, operand registers 0.
  - out_valid 0, stall 0 (given in_valid 0).
  - alu_data 0, ZeroFlag 1 (given in_valid 0).

## Timing
- Base ops: zero latency.
- Normal mul/div, issue at cycle 0:
  - stall high for cycles 0..ITER.
  - DONE at cycle ITER+1 with out_valid = 1.
  - Instruction occupies EX for ITER+2 cycles.
- Special-case divide: stall at cycle 0, DONE at cycle 1.
- Forwarded inputs may change after cycle 0; the result depends only on the values latched at cycle 0.
- Back-to-back M ops: the second issues in the cycle after DONE.
- No combinational path from in_valid or operands to alu_data during BUSY.

## Structure
- Shared package, added to common:
  - muldiv_op_type enum.
  - IsMulDiv and MulDivOp fields in control_type.
  - mux_control_type (already present).
  - MULDIV_IDLE/BUSY/DONE state enum.
- Sub-module muldiv_unit holds the FSM, counter, operand latches and iteration datapath, with a start/busy/done/flush interface.
- Existing alu and forwarding_unit are reused unchanged.

## Test plan
All cases use XLEN = 32, BITS_PER_CYCLE = 1.
- MUL 7 × 0xFFFFFFFD -> stall high for 33 cycles; cycle 33 gives out_valid = 1, alu_data 0xFFFFFFEB, rd_out = rd_in.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIVU 100 / 7 -> 14, REMU -> 2.
- DIVU 5 / 0 -> 0xFFFFFFFF at cycle 1. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1. REM of the same -> 0.
- DIVU with rs1 forwarded from EX/MEM = 100 at cycle 0, forward_ex_mem changed to 0 at cycle 1, rs2 = 7 -> result 14.
- Abort cases:
  - rst pulse at cycle 10 of a MUL -> stall and out_valid drop immediately; next ADD 1 + 2 gives alu_data 3 with no stall.
  - flush at cycle 5 -> no out_valid for that MUL.
